// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM encoding, default sizing
// and a small address helper.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam int DEPTH_WORDS_DEFAULT = 64;
    localparam int WAIT_CYCLES_DEFAULT = 2;

    function automatic logic is_misaligned(input logic [31:0] byte_addr);
        return byte_addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word storage: synchronous write, combinational read.
// Contents are never cleared; unwritten words read as whatever the RAM holds.
module mem_array #(
    parameter int DEPTH_WORDS = 64
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder: IDLE -> BUSY (WAIT_CYCLES) -> DONE -> IDLE.
// Optional alignment checking is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);

    localparam int IW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            we_q, we_d;
    logic            mis_q, mis_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            ready_q, ready_d;
    logic            err_q, err_d;
    logic [31:0]     rdata_q, rdata_d;

    logic            req_mis;
    logic            mem_we;
    logic [31:0]     mem_rdata;

`ifdef MEM_ALIGN_CHECK_EN
    logic unused_addr_bits;
    assign req_mis          = is_misaligned(addr);
    assign unused_addr_bits = ^addr[31:IW+2];
`else
    logic unused_addr_bits;
    assign req_mis          = 1'b0;
    assign unused_addr_bits = ^{addr[31:IW+2], addr[1:0]};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        mis_d   = mis_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        rdata_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    we_d    = we;
                    mis_d   = req_mis;
                    idx_d   = addr[IW+1:2];
                    wdata_d = wdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                // Outputs are registered, so the completion pulse is visible
                // in the cycle after DONE, alongside the write commit.
                state_d = ST_IDLE;
                ready_d = 1'b1;
                err_d   = mis_q;
                if (!we_q && !mis_q) begin
                    rdata_d = mem_rdata;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset gates the commit so an access aborted in DONE never lands.
    assign mem_we = (state_q == ST_DONE) && we_q && !mis_q && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            mis_q   <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            mis_q   <= mis_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
    end

    mem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk  (clk),
        .we   (mem_we),
        .addr (idx_q),
        .wdata(wdata_q),
        .rdata(mem_rdata)
    );

    assign ready = ready_q;
    assign err   = err_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances with WAIT_CYCLES 0, 1, 2,
// a vector table of accesses plus hand-written reset-abort and back-to-back sequences.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset_v [3];
    logic        req_v   [3];
    logic        we_v    [3];
    logic [31:0] addr_v  [3];
    logic [31:0] wdata_v [3];
    logic [31:0] rdata_v [3];
    logic        ready_v [3];
    logic        err_v   [3];

    int checks = 0;
    int errors = 0;

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_ON = 1'b1;
`else
    localparam bit ALIGN_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        mem_responder #(
            .DEPTH_WORDS(64),
            .WAIT_CYCLES(gi)
        ) u_dut (
            .clk  (clk),
            .reset(reset_v[gi]),
            .req  (req_v[gi]),
            .we   (we_v[gi]),
            .addr (addr_v[gi]),
            .wdata(wdata_v[gi]),
            .rdata(rdata_v[gi]),
            .ready(ready_v[gi]),
            .err  (err_v[gi])
        );
    end

    typedef struct {
        int          u;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One access; inputs are scrambled right after acceptance to prove they are latched.
    task automatic do_access(input int u, input bit w, input logic [31:0] a, input logic [31:0] d,
                             output logic [31:0] rd, output logic er, output int lat,
                             output logic pulse_after);
        @(negedge clk);
        req_v[u] = 1'b1; we_v[u] = w; addr_v[u] = a; wdata_v[u] = d;
        @(posedge clk);
        @(negedge clk);
        req_v[u] = 1'b0; we_v[u] = ~w; addr_v[u] = $urandom; wdata_v[u] = $urandom;
        lat = -1; rd = '0; er = 1'b0; pulse_after = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (ready_v[u]) begin
                lat = k; rd = rdata_v[u]; er = err_v[u];
                break;
            end
        end
        @(posedge clk); #1;
        pulse_after = ready_v[u];
    endtask

    task automatic run_vec(input int i);
        logic [31:0] rd;
        logic        er;
        logic        pa;
        int          lat;
        vec_t        v;
        v = vecs[i];
        do_access(v.u, v.we, v.addr, v.wdata, rd, er, lat, pa);
        $display("txn %0d: W=%0d we=%0b addr=%h wdata=%h -> rdata=%h err=%0b latency=%0d",
                 i, v.u, v.we, v.addr, v.wdata, rd, er, lat);
        chk($sformatf("vec%0d latency", i), lat, v.u + 1);
        chk($sformatf("vec%0d rdata", i), rd, v.exp_rdata);
        chk($sformatf("vec%0d err", i), {31'd0, er}, {31'd0, v.exp_err});
        chk($sformatf("vec%0d single pulse", i), {31'd0, pa}, 32'd0);
    endtask

    task automatic reset_abort(input int u, input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] exp_old);
        logic [31:0] rd;
        logic        er;
        logic        pa;
        int          lat;
        int          seen;
        @(negedge clk);
        req_v[u] = 1'b1; we_v[u] = 1'b1; addr_v[u] = a; wdata_v[u] = d;
        @(posedge clk);
        @(negedge clk);
        req_v[u] = 1'b0; reset_v[u] = 1'b1;
        @(posedge clk); #1;
        chk($sformatf("abort W%0d ready after reset", u), {31'd0, ready_v[u]}, 32'd0);
        chk($sformatf("abort W%0d err after reset", u), {31'd0, err_v[u]}, 32'd0);
        chk($sformatf("abort W%0d rdata after reset", u), rdata_v[u], 32'd0);
        @(negedge clk);
        reset_v[u] = 1'b0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (ready_v[u]) seen++;
        end
        chk($sformatf("abort W%0d no ready", u), seen, 32'd0);
        do_access(u, 1'b0, a, 32'h0, rd, er, lat, pa);
        $display("txn abort W=%0d addr=%h -> reread rdata=%h latency=%0d", u, a, rd, lat);
        chk($sformatf("abort W%0d reread", u), rd, exp_old);
        chk($sformatf("abort W%0d reread latency", u), lat, u + 1);
    endtask

    // WAIT_CYCLES=1 with req held: accepts at edges 0,3,6,9 -> ready after edges 2,5,8,11.
    task automatic held_req();
        logic        exp_rdy;
        logic [31:0] exp_rd;
        @(negedge clk);
        req_v[1] = 1'b1; we_v[1] = 1'b0; addr_v[1] = 32'h40; wdata_v[1] = 32'h0;
        @(posedge clk);
        @(negedge clk);
        addr_v[1] = 32'h44; wdata_v[1] = 32'hFFFF_0000;
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk); #1;
            exp_rdy = (k % 3 == 2);
            exp_rd  = !exp_rdy ? 32'h0 : (k == 2 ? 32'h1616_1616 : 32'h1717_1717);
            $display("txn held k=%0d ready=%0b rdata=%h", k, ready_v[1], rdata_v[1]);
            chk($sformatf("held k%0d ready", k), {31'd0, ready_v[1]}, {31'd0, exp_rdy});
            chk($sformatf("held k%0d rdata", k), rdata_v[1], exp_rd);
            chk($sformatf("held k%0d err", k), {31'd0, err_v[1]}, 32'd0);
        end
        @(negedge clk);
        req_v[1] = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int u = 0; u < 3; u++) begin
            reset_v[u] = 1'b1; req_v[u] = 1'b0; we_v[u] = 1'b0;
            addr_v[u] = '0; wdata_v[u] = '0;
        end

        vecs.push_back('{2, 1'b1, 32'h10,  32'hDEAD_BEEF, 32'h0,         1'b0});
        vecs.push_back('{2, 1'b0, 32'h10,  32'h0,         32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{0, 1'b1, 32'h04,  32'h1234_5678, 32'h0,         1'b0});
        vecs.push_back('{0, 1'b0, 32'h04,  32'h0,         32'h1234_5678, 1'b0});
        vecs.push_back('{2, 1'b1, 32'h100, 32'hA5A5_A5A5, 32'h0,         1'b0});
        vecs.push_back('{2, 1'b0, 32'h000, 32'h0,         32'hA5A5_A5A5, 1'b0});
        vecs.push_back('{2, 1'b0, 32'h10,  32'h0,         32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{1, 1'b1, 32'hFC,  32'h0BAD_F00D, 32'h0,         1'b0});
        vecs.push_back('{1, 1'b0, 32'h1FC, 32'h0,         32'h0BAD_F00D, 1'b0});
        vecs.push_back('{1, 1'b1, 32'h40,  32'h1616_1616, 32'h0,         1'b0});
        vecs.push_back('{1, 1'b1, 32'h44,  32'h1717_1717, 32'h0,         1'b0});
        vecs.push_back('{2, 1'b1, 32'h20,  32'h1111_1111, 32'h0,         1'b0});
        vecs.push_back('{2, 1'b0, 32'h20,  32'h0,         32'h1111_1111, 1'b0});
        // Phase B: misaligned write then reread of the aligned word.
        vecs.push_back('{2, 1'b1, 32'h22,  32'hCAFE_F00D, 32'h0,         ALIGN_ON});
        vecs.push_back('{2, 1'b0, 32'h20,  32'h0,
                         ALIGN_ON ? 32'h1111_1111 : 32'hCAFE_F00D,      1'b0});

        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("reset W%0d ready", u), {31'd0, ready_v[u]}, 32'd0);
            chk($sformatf("reset W%0d err", u), {31'd0, err_v[u]}, 32'd0);
            chk($sformatf("reset W%0d rdata", u), rdata_v[u], 32'd0);
        end
        @(negedge clk);
        for (int u = 0; u < 3; u++) reset_v[u] = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 13; i++) run_vec(i);

        reset_abort(2, 32'h20, 32'hFFFF_FFFF, 32'h1111_1111);
        reset_abort(0, 32'h04, 32'hFFFF_FFFF, 32'h1234_5678);
        held_req();

        for (int i = 13; i < vecs.size(); i++) run_vec(i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
